// File: rtl/tdc_pkg.sv
// Shared constants, helper function and timestamp layout for the TDC thermometer encoder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package tdc_pkg;

  localparam int NFF_DEF      = 208;  // delay-line taps
  localparam int COARSE_W_DEF = 16;   // coarse counter width
  localparam int GRP_DEF      = 16;   // taps per first-level popcount group

  // Ceiling log2; clog2(v) bits hold values 0..v-1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  localparam int FINE_W_DEF = clog2(NFF_DEF + 1);
  localparam int TS_W_DEF   = COARSE_W_DEF + FINE_W_DEF + 1;

  // One timestamp word as handed to readout logic (default geometry).
  typedef struct packed {
    logic [COARSE_W_DEF-1:0] coarse;
    logic [FINE_W_DEF-1:0]   fine;
    logic                    sat;
  } ts_t;

endpackage

// File: rtl/thermo_popcount.sv
// Combinational population count of a W-bit tap group.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: bits_in [W-1:0] tap group; cnt [clog2(W+1)-1:0] number of ones in bits_in.
module thermo_popcount
  import tdc_pkg::*;
#(
  parameter int W = GRP_DEF,
  localparam int CW = clog2(W + 1)
) (
  input  logic [W-1:0]  bits_in,
  output logic [CW-1:0] cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < W; i++) begin
      cnt = cnt + CW'(bits_in[i]);
    end
  end

endmodule

// File: rtl/tdc_thermo_encoder.sv
// Turns a registered delay-line snapshot into a (coarse, fine, sat) timestamp per hit.
// Latency: 3 cycles from the hit cycle to the one-cycle ts_valid strobe.
// Backpressure: none; a hit is accepted on any cycle and always emerges on schedule.
// Ports: clk, rst_n (sync, active-low); therm_in [NFF-1:0] tap snapshot, bit 0 nearest
//   the hit input; en gates new hits only; ts_valid strobe with ts_coarse (hit-cycle
//   coarse count), ts_fine (ones in snapshot), ts_sat (ts_fine == NFF).
module tdc_thermo_encoder
  import tdc_pkg::*;
#(
  parameter int NFF      = NFF_DEF,
  parameter int COARSE_W = COARSE_W_DEF,
  parameter int GRP      = GRP_DEF,
  localparam int FINE_W  = clog2(NFF + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NFF-1:0]      therm_in,
  input  logic                en,
  output logic                ts_valid,
  output logic [COARSE_W-1:0] ts_coarse,
  output logic [FINE_W-1:0]   ts_fine,
  output logic                ts_sat
);

  localparam int NG  = (NFF + GRP - 1) / GRP;
  localparam int GCW = clog2(GRP + 1);

  // Zero-pad the snapshot to a whole number of groups; padding adds nothing to the count.
  logic [NG*GRP-1:0] therm_pad;
  assign therm_pad = (NG*GRP)'(therm_in);

  logic [GCW-1:0] grp_cnt [NG];

  for (genvar g = 0; g < NG; g++) begin : g_pc
    thermo_popcount #(.W(GRP)) u_pc (
      .bits_in (therm_pad[g*GRP +: GRP]),
      .cnt     (grp_cnt[g])
    );
  end

  logic [COARSE_W-1:0] coarse_q, coarse_d;
  logic                tap0_q, tap0_d;
  logic                v1_q, v1_d;
  logic [COARSE_W-1:0] s1_coarse_q, s1_coarse_d;
  logic [GCW-1:0]      s1_cnt_q [NG];
  logic [GCW-1:0]      s1_cnt_d [NG];
  logic                v2_q, v2_d;
  logic [COARSE_W-1:0] s2_coarse_q, s2_coarse_d;
  logic [FINE_W-1:0]   s2_total_q, s2_total_d;
  logic                ts_valid_q, ts_valid_d;
  logic [COARSE_W-1:0] ts_coarse_q, ts_coarse_d;
  logic [FINE_W-1:0]   ts_fine_q, ts_fine_d;
  logic                ts_sat_q, ts_sat_d;
  logic                hit;

  // Rising edge on tap 0; tap0_q tracks the line even while en is low so that
  // re-enabling on an already-high line does not fabricate a hit.
  assign hit = en & therm_in[0] & ~tap0_q;

  always_comb begin
    coarse_d    = coarse_q + COARSE_W'(1);
    tap0_d      = therm_in[0];

    // S1: group counts and coarse stamp of the hit cycle
    v1_d        = hit;
    s1_coarse_d = coarse_q;
    for (int g = 0; g < NG; g++) begin
      s1_cnt_d[g] = grp_cnt[g];
    end

    // S2: fold the group counts; total never exceeds NFF so FINE_W cannot overflow
    v2_d        = v1_q;
    s2_coarse_d = s1_coarse_q;
    s2_total_d  = '0;
    for (int g = 0; g < NG; g++) begin
      s2_total_d = s2_total_d + FINE_W'(s1_cnt_q[g]);
    end

    // S3: output registers keep the last timestamp between strobes
    ts_valid_d  = v2_q;
    ts_coarse_d = ts_coarse_q;
    ts_fine_d   = ts_fine_q;
    ts_sat_d    = ts_sat_q;
    if (v2_q) begin
      ts_coarse_d = s2_coarse_q;
      ts_fine_d   = s2_total_q;
      ts_sat_d    = (s2_total_q == FINE_W'(NFF));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      coarse_q    <= '0;
      tap0_q      <= 1'b1;
      v1_q        <= 1'b0;
      s1_coarse_q <= '0;
      for (int g = 0; g < NG; g++) begin
        s1_cnt_q[g] <= '0;
      end
      v2_q        <= 1'b0;
      s2_coarse_q <= '0;
      s2_total_q  <= '0;
      ts_valid_q  <= 1'b0;
      ts_coarse_q <= '0;
      ts_fine_q   <= '0;
      ts_sat_q    <= 1'b0;
    end else begin
      coarse_q    <= coarse_d;
      tap0_q      <= tap0_d;
      v1_q        <= v1_d;
      s1_coarse_q <= s1_coarse_d;
      for (int g = 0; g < NG; g++) begin
        s1_cnt_q[g] <= s1_cnt_d[g];
      end
      v2_q        <= v2_d;
      s2_coarse_q <= s2_coarse_d;
      s2_total_q  <= s2_total_d;
      ts_valid_q  <= ts_valid_d;
      ts_coarse_q <= ts_coarse_d;
      ts_fine_q   <= ts_fine_d;
      ts_sat_q    <= ts_sat_d;
    end
  end

  assign ts_valid  = ts_valid_q;
  assign ts_coarse = ts_coarse_q;
  assign ts_fine   = ts_fine_q;
  assign ts_sat    = ts_sat_q;

endmodule
